// File: rtl/layer2_sequencer.sv
// Layer-2 control sequencer: per output neuron, load a weight-2 row, step the hidden
// activations through the MAC, wait out the sigmoid, then write the answer SRAM.
module layer2_sequencer #(
    parameter int N_HID   = 10,
    parameter int N_OUT   = 10,
    parameter int W2_LAT  = 1,
    parameter int RD_LAT  = 1,
    parameter int SIG_LAT = 1
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic [3:0] base_row_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [3:0] w2_addr_o,
    output logic [4:0] hid_addr_o,
    output logic [4:0] w_sel_o,
    output logic       mac_en_o,
    output logic       mac_clear_o,
    output logic       gsram_we_o,
    output logic [3:0] gsram_row_o,
    output logic [3:0] gsram_col_o
);
    localparam int OW   = $clog2(N_OUT + 1);
    localparam int KW   = $clog2(N_HID + 1);
    localparam int LMAX = (W2_LAT > RD_LAT) ? ((W2_LAT > SIG_LAT) ? W2_LAT : SIG_LAT)
                                            : ((RD_LAT > SIG_LAT) ? RD_LAT : SIG_LAT);
    localparam int LW   = $clog2(LMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ACC, S_DRAIN, S_SIG, S_WRITE, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [OW-1:0] o_q, o_d;
    logic [KW-1:0] k_q, k_d;
    logic [LW-1:0] lat_q, lat_d;
    logic          accept;

    logic          busy_q, done_q, we_q;
    logic [3:0]    w2_addr_q, row_q, col_q;
    logic [4:0]    hid_addr_q;
    logic [RD_LAT:0] vld_pipe_q, clr_pipe_q;

    always_comb begin
        state_d = state_q;
        o_d     = o_q;
        k_d     = k_q;
        lat_d   = lat_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: if (start_i) begin
                state_d = S_LOAD;
                o_d     = '0;
                k_d     = '0;
                lat_d   = '0;
                accept  = 1'b1;
            end
            S_LOAD: if (lat_q == LW'(W2_LAT - 1)) begin
                state_d = S_ACC;
                k_d     = '0;
                lat_d   = '0;
            end else lat_d = lat_q + 1'b1;
            S_ACC: begin
                k_d = k_q + 1'b1;
                if (k_q == KW'(N_HID - 1)) state_d = S_DRAIN;
            end
            S_DRAIN: if (lat_q == LW'(RD_LAT - 1)) begin
                state_d = S_SIG;
                lat_d   = '0;
            end else lat_d = lat_q + 1'b1;
            S_SIG: if (lat_q == LW'(SIG_LAT - 1)) begin
                state_d = S_WRITE;
                lat_d   = '0;
            end else lat_d = lat_q + 1'b1;
            S_WRITE: if (o_q == OW'(N_OUT - 1)) state_d = S_DONE;
            else begin
                o_d     = o_q + 1'b1;
                state_d = S_LOAD;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // abort overrides everything, including a start seen in the same cycle
        if (abort_i) begin
            state_d = S_IDLE;
            o_d     = '0;
            k_d     = '0;
            lat_d   = '0;
            accept  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            o_q     <= '0;
            k_q     <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            o_q     <= o_d;
            k_q     <= k_d;
            lat_q   <= lat_d;
        end
    end

    // Outputs are registered one cycle behind the state they describe.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            we_q       <= 1'b0;
            w2_addr_q  <= '0;
            hid_addr_q <= '0;
            row_q      <= '0;
            col_q      <= '0;
            vld_pipe_q <= '0;
            clr_pipe_q <= '0;
        end else begin
            busy_q <= (state_q != S_IDLE) && (state_q != S_DONE);
            done_q <= (state_q == S_DONE);
            we_q   <= (state_q == S_WRITE);
            if (state_q == S_LOAD)  w2_addr_q  <= 4'(o_q);
            if (state_q == S_ACC)   hid_addr_q <= 5'(k_q);
            if (state_q == S_WRITE) col_q      <= 4'(o_q);
            if (accept)             row_q      <= base_row_i;
            vld_pipe_q <= {vld_pipe_q[RD_LAT-1:0], state_q == S_ACC};
            clr_pipe_q <= {clr_pipe_q[RD_LAT-1:0], (state_q == S_ACC) && (k_q == '0)};
            // the output stage still shows this cycle; everything behind it is flushed
            if (abort_i) begin
                vld_pipe_q[RD_LAT-1:0] <= '0;
                clr_pipe_q[RD_LAT-1:0] <= '0;
            end
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign w2_addr_o   = w2_addr_q;
    assign hid_addr_o  = hid_addr_q;
    assign w_sel_o     = hid_addr_q;
    assign mac_en_o    = vld_pipe_q[RD_LAT];
    assign mac_clear_o = clr_pipe_q[RD_LAT];
    assign gsram_we_o  = we_q;
    assign gsram_row_o = row_q;
    assign gsram_col_o = col_q;
endmodule
